// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the core's two requesters, the arbiter and the downstream port.
interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  fetch_request_enable;
   logic                  freq_mode;
   logic [ADDR_W-1:0]     freq_addr;
   logic [DATA_W-1:0]     freq_wdata;
   logic [DATA_W/8-1:0]   freq_wstrb;
   logic                  fetch_response_enable;
   logic [DATA_W-1:0]     fresp_data;

   logic                  mem_request_enable;
   logic                  mreq_mode;
   logic [ADDR_W-1:0]     mreq_addr;
   logic [DATA_W-1:0]     mreq_wdata;
   logic [DATA_W/8-1:0]   mreq_wstrb;
   logic                  mem_response_enable;
   logic [DATA_W-1:0]     mresp_data;

   logic                  bus_request_enable;
   logic                  breq_mode;
   logic [ADDR_W-1:0]     breq_addr;
   logic [DATA_W-1:0]     breq_wdata;
   logic [DATA_W/8-1:0]   breq_wstrb;
   logic                  bus_response_enable;
   logic [DATA_W-1:0]     bresp_data;

   logic                  proto_err;

   modport slave (
      input  fetch_request_enable, freq_mode, freq_addr, freq_wdata, freq_wstrb,
      input  mem_request_enable, mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb,
      input  bus_response_enable, bresp_data,
      output fetch_response_enable, fresp_data,
      output mem_response_enable, mresp_data,
      output bus_request_enable, breq_mode, breq_addr, breq_wdata, breq_wstrb,
      output proto_err
   );

   modport master (
      output fetch_request_enable, freq_mode, freq_addr, freq_wdata, freq_wstrb,
      output mem_request_enable, mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb,
      output bus_response_enable, bresp_data,
      input  fetch_response_enable, fresp_data,
      input  mem_response_enable, mresp_data,
      input  bus_request_enable, breq_mode, breq_addr, breq_wdata, breq_wstrb,
      input  proto_err
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one downstream bus port between fetch and data requesters,
// with one transaction in flight and responses routed back to the issuer.
module mem_bus_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic              clk,
   input logic              rst,
   mem_bus_arbiter_if.slave arb
);
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_M} state_t;
   state_t state, state_nxt;

   logic              f_valid, f_mode, m_valid, m_mode;
   logic [ADDR_W-1:0] f_addr, m_addr;
   logic [DATA_W-1:0] f_wdata, m_wdata;
   logic [STRB_W-1:0] f_wstrb, m_wstrb;
   logic              last_grant;  // 1: mem was granted most recently
   logic              f_acc, m_acc, f_pend, m_pend, can_grant, grant_f, grant_m;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // A request arriving this cycle is eligible for grant immediately, bypassing its slot.
   always_comb begin
      f_acc     = arb.fetch_request_enable && !f_valid && (state != BUSY_F);
      m_acc     = arb.mem_request_enable && !m_valid && (state != BUSY_M);
      f_pend    = f_valid || f_acc;
      m_pend    = m_valid || m_acc;
      can_grant = (state == IDLE) || arb.bus_response_enable;
      grant_f   = 1'b0;
      grant_m   = 1'b0;
      if (can_grant) begin
         if (f_pend && m_pend) begin
            grant_f = last_grant;
            grant_m = !last_grant;
         end else begin
            grant_f = f_pend;
            grant_m = m_pend;
         end
      end
      state_nxt = state;
      if (state != IDLE && arb.bus_response_enable) state_nxt = IDLE;
      if (grant_f)      state_nxt = BUSY_F;
      else if (grant_m) state_nxt = BUSY_M;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         f_valid <= 1'b0; f_mode <= 1'b0; f_addr <= '0; f_wdata <= '0; f_wstrb <= '0;
         m_valid <= 1'b0; m_mode <= 1'b0; m_addr <= '0; m_wdata <= '0; m_wstrb <= '0;
         last_grant                <= 1'b1;
         arb.bus_request_enable    <= 1'b0;
         arb.breq_mode             <= 1'b0;
         arb.breq_addr             <= '0;
         arb.breq_wdata            <= '0;
         arb.breq_wstrb            <= '0;
         arb.fetch_response_enable <= 1'b0;
         arb.fresp_data            <= '0;
         arb.mem_response_enable   <= 1'b0;
         arb.mresp_data            <= '0;
         arb.proto_err             <= 1'b0;
      end else begin
         arb.bus_request_enable    <= grant_f || grant_m;
         arb.fetch_response_enable <= 1'b0;
         arb.mem_response_enable   <= 1'b0;

         if (grant_f) begin
            arb.breq_mode  <= f_valid ? f_mode  : arb.freq_mode;
            arb.breq_addr  <= f_valid ? f_addr  : arb.freq_addr;
            arb.breq_wdata <= f_valid ? f_wdata : arb.freq_wdata;
            arb.breq_wstrb <= f_valid ? f_wstrb : arb.freq_wstrb;
            last_grant     <= 1'b0;
         end else if (grant_m) begin
            arb.breq_mode  <= m_valid ? m_mode  : arb.mreq_mode;
            arb.breq_addr  <= m_valid ? m_addr  : arb.mreq_addr;
            arb.breq_wdata <= m_valid ? m_wdata : arb.mreq_wdata;
            arb.breq_wstrb <= m_valid ? m_wstrb : arb.mreq_wstrb;
            last_grant     <= 1'b1;
         end

         if (grant_f) begin
            f_valid <= 1'b0;
         end else if (f_acc) begin
            f_valid <= 1'b1;
            f_mode  <= arb.freq_mode;
            f_addr  <= arb.freq_addr;
            f_wdata <= arb.freq_wdata;
            f_wstrb <= arb.freq_wstrb;
         end

         if (grant_m) begin
            m_valid <= 1'b0;
         end else if (m_acc) begin
            m_valid <= 1'b1;
            m_mode  <= arb.mreq_mode;
            m_addr  <= arb.mreq_addr;
            m_wdata <= arb.mreq_wdata;
            m_wstrb <= arb.mreq_wstrb;
         end

         if (arb.bus_response_enable && state == BUSY_F) begin
            arb.fetch_response_enable <= 1'b1;
            arb.fresp_data            <= arb.bresp_data;
         end
         if (arb.bus_response_enable && state == BUSY_M) begin
            arb.mem_response_enable <= 1'b1;
            arb.mresp_data          <= arb.bresp_data;
         end

         if ((arb.fetch_request_enable && !f_acc) || (arb.mem_request_enable && !m_acc) ||
             (arb.bus_response_enable && state == IDLE))
            arb.proto_err <= 1'b1;
      end
   end
endmodule
